// File: rtl/config_counter.sv
// Up/down counter with a configurable modulus and wrap, saturate or one-shot behaviour,
// plus a parallel load. Reset is synchronous; there is no asynchronous path.
module config_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             done
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] stepped;
  logic             at_term;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  // The terminal value follows the current direction, so tc and wrap react to up immediately.
  always_comb begin
    term    = up ? MaxVal : '0;
    at_term = (count_q == term);
    // Only used when not at terminal, so it never leaves 0..MaxVal.
    stepped = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  end

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
      done_d  = 1'b0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          if (!at_term) count_d = stepped;
        end
        2'b10: begin
          // Once done, the count is frozen until a load or reset.
          if (!done_q) begin
            if (at_term) begin
              done_d = 1'b1;
            end else begin
              count_d = stepped;
              done_d  = (stepped == term);
            end
          end
        end
        default: begin
          if (at_term) begin
            count_d = up ? '0 : MaxVal;
            wrap_d  = 1'b1;
          end else begin
            count_d = stepped;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q          = count_q;
  assign done       = done_q;
  assign wrap_pulse = wrap_q;
  assign tc         = en & at_term;

endmodule
